// File: rtl/ls_unit.sv
// ls_unit: load/store execution unit sitting behind the load/store buffer.
//
// Accepts one memory operation at a time, forms the effective address
// (operandO + imm) and performs the access one byte at a time over the
// byte-wide memory-controller port. Loads are reassembled little-endian,
// sign- or zero-extended and broadcast on the LS result bus. Every completed
// operation, load or store, pulses LSdone for one cycle so the buffer can
// retire its head entry.
//
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned
// halfword/word accesses. A rejected access issues no memory request,
// completes immediately (a load returns 0 with its tag) and sets the sticky
// misalignErr flag. Without the macro, misaligned accesses proceed byte by
// byte like any other access and misalignErr stays 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   LSworkEn            issued operation valid
//   operandO, imm       base and offset of the effective address
//   operandT            store data
//   wrtTag, wrtName     destination tag/name of a load
//   opCode              LB/LH/LW/LBU/LHU/SB/SH/SW
//   LSreadEn            unit can accept an operation next cycle (combinational)
//   LSdone              one-cycle completion pulse
//   enLSwrt, LStag,
//   LSname, LSdata      load result broadcast
//   memReq, memWr,
//   memAddr, memWdata   byte request to the memory controller
//   memAck, memRdata    byte completion and read data from the controller
//   misalignErr         sticky misalignment flag

module ls_unit #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int NAME_W = 5,
    parameter int OP_W   = 6,
    parameter logic [OP_W-1:0] OP_LB  = OP_W'(6'h20),
    parameter logic [OP_W-1:0] OP_LH  = OP_W'(6'h21),
    parameter logic [OP_W-1:0] OP_LW  = OP_W'(6'h23),
    parameter logic [OP_W-1:0] OP_LBU = OP_W'(6'h24),
    parameter logic [OP_W-1:0] OP_LHU = OP_W'(6'h25),
    parameter logic [OP_W-1:0] OP_SB  = OP_W'(6'h28),
    parameter logic [OP_W-1:0] OP_SH  = OP_W'(6'h29),
    parameter logic [OP_W-1:0] OP_SW  = OP_W'(6'h2B)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LSworkEn,
    input  logic [DATA_W-1:0] operandO,
    input  logic [DATA_W-1:0] operandT,
    input  logic [DATA_W-1:0] imm,
    input  logic [TAG_W-1:0]  wrtTag,
    input  logic [NAME_W-1:0] wrtName,
    input  logic [OP_W-1:0]   opCode,
    output logic              LSreadEn,
    output logic              LSdone,
    output logic              enLSwrt,
    output logic [TAG_W-1:0]  LStag,
    output logic [NAME_W-1:0] LSname,
    output logic [DATA_W-1:0] LSdata,
    output logic              memReq,
    output logic              memWr,
    output logic [DATA_W-1:0] memAddr,
    output logic [7:0]        memWdata,
    input  logic              memAck,
    input  logic [7:0]        memRdata,
    output logic              misalignErr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    // Latched operation
    logic [1:0]        k_q, k_d;          // byte currently being transferred
    logic [1:0]        last_q, last_d;    // index of the final byte (n-1)
    logic              store_q, store_d;
    logic              sext_q, sext_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [NAME_W-1:0] name_q, name_d;

    // Registered outputs
    logic              mem_req_q, mem_req_d;
    logic              mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              ls_done_q, ls_done_d;
    logic              en_wrt_q, en_wrt_d;
    logic [TAG_W-1:0]  ls_tag_q, ls_tag_d;
    logic [NAME_W-1:0] ls_name_q, ls_name_d;
    logic [DATA_W-1:0] ls_data_q, ls_data_d;
    logic              misalign_q, misalign_d;

    // Decode of the incoming operation
    logic              dec_store;
    logic              dec_sext;
    logic [1:0]        dec_last;
    logic              dec_misalign;
    logic [DATA_W-1:0] eff_addr;

    logic [1:0]        k_nxt;
    logic [DATA_W-1:0] assembled;
    logic [DATA_W-1:0] extended;

    assign eff_addr = operandO + imm;
    assign k_nxt    = k_q + 2'd1;

    // Load word with the byte arriving this cycle merged into its lane.
    assign assembled = rdata_q | (DATA_W'(memRdata) << {k_q, 3'b000});

    // Opcode decode. Unrecognised opcodes are run as a word load so the
    // buffer still sees a completion and never stalls on a bad entry.
    always_comb begin
        dec_store = 1'b0;
        dec_sext  = 1'b0;
        dec_last  = 2'd3;
        case (opCode)
            OP_LB:   begin dec_last = 2'd0; dec_sext = 1'b1; end
            OP_LH:   begin dec_last = 2'd1; dec_sext = 1'b1; end
            OP_LW:   begin dec_last = 2'd3; end
            OP_LBU:  begin dec_last = 2'd0; end
            OP_LHU:  begin dec_last = 2'd1; end
            OP_SB:   begin dec_last = 2'd0; dec_store = 1'b1; end
            OP_SH:   begin dec_last = 2'd1; dec_store = 1'b1; end
            OP_SW:   begin dec_last = 2'd3; dec_store = 1'b1; end
            default: begin dec_last = 2'd3; end
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    assign dec_misalign = ((dec_last == 2'd1) && eff_addr[0]) ||
                          ((dec_last == 2'd3) && (eff_addr[1:0] != 2'b00));
`else
    assign dec_misalign = 1'b0;
`endif

    // Width handling of the final load value; bytes above the access size
    // are still zero in the assembly register, so a word needs no change.
    always_comb begin
        extended = assembled;
        if (last_q == 2'd0) begin
            extended = {{(DATA_W-8){sext_q & assembled[7]}}, assembled[7:0]};
        end else if (last_q == 2'd1) begin
            extended = {{(DATA_W-16){sext_q & assembled[15]}}, assembled[15:0]};
        end
    end

    // Next-state and output computation. Completion outputs default to 0 so
    // that LSdone/enLSwrt are single-cycle pulses.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        last_d      = last_q;
        store_d     = store_q;
        sext_d      = sext_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        tag_d       = tag_q;
        name_d      = name_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ls_done_d   = 1'b0;
        en_wrt_d    = 1'b0;
        ls_tag_d    = '0;
        ls_name_d   = '0;
        ls_data_d   = '0;
        misalign_d  = misalign_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (LSworkEn) begin
                    k_d     = 2'd0;
                    last_d  = dec_last;
                    store_d = dec_store;
                    sext_d  = dec_sext;
                    addr_d  = eff_addr;
                    wdata_d = operandT;
                    rdata_d = '0;
                    tag_d   = wrtTag;
                    name_d  = wrtName;
                    if (dec_misalign) begin
                        // Rejected access: complete at once with a zero result.
                        state_d    = ST_DONE;
                        ls_done_d  = 1'b1;
                        en_wrt_d   = ~dec_store;
                        ls_tag_d   = dec_store ? '0 : wrtTag;
                        ls_name_d  = dec_store ? '0 : wrtName;
                        misalign_d = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_wr_d    = dec_store;
                        mem_addr_d  = eff_addr;
                        mem_wdata_d = operandT[7:0];
                    end
                end
            end

            ST_ACCESS: begin
                if (memAck && mem_req_q) begin
                    rdata_d = assembled;
                    if (k_q == last_q) begin
                        state_d     = ST_DONE;
                        mem_req_d   = 1'b0;
                        mem_wr_d    = 1'b0;
                        mem_addr_d  = '0;
                        mem_wdata_d = '0;
                        ls_done_d   = 1'b1;
                        if (!store_q) begin
                            en_wrt_d  = 1'b1;
                            ls_tag_d  = tag_q;
                            ls_name_d = name_q;
                            ls_data_d = extended;
                        end
                    end else begin
                        // Present the next byte right away; the address
                        // wraps naturally in DATA_W-bit arithmetic.
                        k_d         = k_nxt;
                        mem_addr_d  = addr_q + DATA_W'(k_nxt);
                        mem_wdata_d = wdata_q[{k_nxt, 3'b000} +: 8];
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers. Reset abandons any access in flight; bytes
    // already written by a store stay written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            last_q      <= '0;
            store_q     <= 1'b0;
            sext_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            tag_q       <= '0;
            name_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ls_done_q   <= 1'b0;
            en_wrt_q    <= 1'b0;
            ls_tag_q    <= '0;
            ls_name_q   <= '0;
            ls_data_q   <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            last_q      <= last_d;
            store_q     <= store_d;
            sext_q      <= sext_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            tag_q       <= tag_d;
            name_q      <= name_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ls_done_q   <= ls_done_d;
            en_wrt_q    <= en_wrt_d;
            ls_tag_q    <= ls_tag_d;
            ls_name_q   <= ls_name_d;
            ls_data_q   <= ls_data_d;
            misalign_q  <= misalign_d;
        end
    end

    // Ready is combinational so the buffer sees a same-cycle issue as taken.
    assign LSreadEn = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !LSworkEn;

    assign LSdone      = ls_done_q;
    assign enLSwrt     = en_wrt_q;
    assign LStag       = ls_tag_q;
    assign LSname      = ls_name_q;
    assign LSdata      = ls_data_q;
    assign memReq      = mem_req_q;
    assign memWr       = mem_wr_q;
    assign memAddr     = mem_addr_q;
    assign memWdata    = mem_wdata_q;
    assign misalignErr = misalign_q;

    // An issue while an access is running means the buffer ignored LSreadEn;
    // the unit drops it, and simulation flags it.
    issue_while_busy: assert property (@(posedge clk) disable iff (rst)
        !((state_q == ST_ACCESS) && LSworkEn));

endmodule

// File: tb/tb_ls_unit.sv
// tb_ls_unit: randomized self-checking bench for ls_unit.
//
// A byte-addressed memory with a configurable acknowledge latency answers
// the unit's requests and logs every byte transferred. For each operation a
// reference model computes the address, byte list, load value and
// completion time directly from the load/store rules, and the results are
// compared against the DUT. Directed cases cover the store/load examples,
// wait states, address wrap and reset during a store.

module tb_ls_unit;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic        clk;
    logic        rst;
    logic        LSworkEn;
    logic [31:0] operandO;
    logic [31:0] operandT;
    logic [31:0] imm;
    logic [3:0]  wrtTag;
    logic [4:0]  wrtName;
    logic [5:0]  opCode;
    logic        LSreadEn;
    logic        LSdone;
    logic        enLSwrt;
    logic [3:0]  LStag;
    logic [4:0]  LSname;
    logic [31:0] LSdata;
    logic        memReq;
    logic        memWr;
    logic [31:0] memAddr;
    logic [7:0]  memWdata;
    logic        memAck = 1'b0;
    logic [7:0]  memRdata = 8'h00;
    logic        misalignErr;

    int checks = 0;
    int failures = 0;

    // Memory responder state
    int          ackLat = 1;
    int          cnt = 0;
    int          stabErr = 0;
    logic [31:0] heldAddr;
    logic [7:0]  heldW;
    logic        heldWr;
    logic [39:0] wrQ[$];
    logic [31:0] rdQ[$];
    logic [7:0]  mem [logic [31:0]];

    // Sticky misalignment flag expected by the model
    bit expErr = 1'b0;

    ls_unit dut (
        .clk         (clk),
        .rst         (rst),
        .LSworkEn    (LSworkEn),
        .operandO    (operandO),
        .operandT    (operandT),
        .imm         (imm),
        .wrtTag      (wrtTag),
        .wrtName     (wrtName),
        .opCode      (opCode),
        .LSreadEn    (LSreadEn),
        .LSdone      (LSdone),
        .enLSwrt     (enLSwrt),
        .LStag       (LStag),
        .LSname      (LSname),
        .LSdata      (LSdata),
        .memReq      (memReq),
        .memWr       (memWr),
        .memAddr     (memAddr),
        .memWdata    (memWdata),
        .memAck      (memAck),
        .memRdata    (memRdata),
        .misalignErr (misalignErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are created on first touch so loads of untouched
    // bytes return random data.
    function automatic logic [7:0] getByte(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = 8'($urandom);
        return mem[a];
    endfunction

    // Memory controller model: acknowledges each byte after ackLat cycles of
    // request, checks the request is held stable meanwhile, and throws in
    // stray acknowledges while no request is pending.
    always @(negedge clk) begin
        if (rst) begin
            cnt    = 0;
            memAck = 1'b0;
        end else if (memReq) begin
            if (cnt == 0) begin
                heldAddr = memAddr;
                heldW    = memWdata;
                heldWr   = memWr;
            end else if (memAddr !== heldAddr || memWdata !== heldW || memWr !== heldWr) begin
                stabErr++;
            end
            if (cnt + 1 >= ackLat) begin
                memAck = 1'b1;
                cnt    = 0;
                if (memWr) begin
                    mem[memAddr] = memWdata;
                    wrQ.push_back({memAddr, memWdata});
                end else begin
                    memRdata = getByte(memAddr);
                    rdQ.push_back(memAddr);
                end
            end else begin
                memAck = 1'b0;
                cnt++;
            end
        end else begin
            cnt      = 0;
            memAck   = ($urandom_range(0, 3) == 0);
            memRdata = 8'($urandom);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one operation at the current falling edge, then follows it to
    // completion and checks everything against the reference model.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] base,
                                 input logic [31:0] off, input logic [31:0] sdata,
                                 input logic [3:0] tag, input logic [4:0] name,
                                 input int lat);
        logic [31:0] addr;
        logic [31:0] expData;
        logic [31:0] sh;
        logic [39:0] expW[$];
        logic [31:0] expR[$];
        int          n;
        int          expLat;
        int          j;
        int          busyRdy;
        bit          isLoad;
        bit          isSigned;
        bit          misal;

        addr = base + off;
        case (op)
            OP_LB, OP_LBU, OP_SB: n = 1;
            OP_LH, OP_LHU, OP_SH: n = 2;
            default:              n = 4;
        endcase
        isLoad   = (op != OP_SB) && (op != OP_SH) && (op != OP_SW);
        isSigned = (op == OP_LB) || (op == OP_LH);
        misal    = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        misal = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`endif
        expData = 32'h0;
        if (misal) begin
            expErr = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (isLoad) begin
                    expR.push_back(addr + 32'(i));
                    expData |= 32'(getByte(addr + 32'(i))) << (8 * i);
                end else begin
                    sh = sdata >> (8 * i);
                    expW.push_back({addr + 32'(i), sh[7:0]});
                end
            end
        end
        if (isSigned && n == 1 && expData[7])  expData |= 32'hFFFF_FF00;
        if (isSigned && n == 2 && expData[15]) expData |= 32'hFFFF_0000;
        expLat = misal ? 1 : n * lat + 1;

        ackLat = lat;
        wrQ.delete();
        rdQ.delete();
        LSworkEn = 1'b1;
        opCode   = op;
        operandO = base;
        imm      = off;
        operandT = sdata;
        wrtTag   = tag;
        wrtName  = name;
        @(negedge clk);
        LSworkEn = 1'b0;
        operandO = $urandom;
        operandT = $urandom;
        imm      = $urandom;
        wrtTag   = 4'($urandom);
        wrtName  = 5'($urandom);
        opCode   = 6'($urandom);

        j = 1;
        busyRdy = 0;
        while (!LSdone && j < 200) begin
            if (LSreadEn) busyRdy++;
            @(negedge clk);
            j++;
        end
        checkOutput("done_latency", j, expLat);
        if (!LSdone) return;

        checkOutput("en_wrt", enLSwrt, isLoad);
        if (isLoad) begin
            checkOutput("ls_tag", LStag, tag);
            checkOutput("ls_name", LSname, name);
            checkOutput("ls_data", LSdata, expData);
        end
        checkOutput("wr_count", wrQ.size(), expW.size());
        checkOutput("rd_count", rdQ.size(), expR.size());
        for (int i = 0; i < expW.size() && i < wrQ.size(); i++)
            checkOutput($sformatf("wr_byte%0d", i), wrQ[i], expW[i]);
        for (int i = 0; i < expR.size() && i < rdQ.size(); i++)
            checkOutput($sformatf("rd_addr%0d", i), rdQ[i], expR[i]);
        checkOutput("busy_ready", busyRdy, 0);
        checkOutput("misalign_err", misalignErr, expErr);
    endtask

    initial begin
        logic [5:0] ops [8];
        int         j;
        logic [31:0] base;
        logic [31:0] off;

        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

        rst      = 1'b1;
        LSworkEn = 1'b0;
        operandO = '0;
        operandT = '0;
        imm      = '0;
        wrtTag   = '0;
        wrtName  = '0;
        opCode   = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", LSreadEn, 1);
        checkOutput("rst_memreq", memReq, 0);
        checkOutput("rst_memaddr", memAddr, 0);
        checkOutput("rst_done", LSdone, 0);
        checkOutput("rst_enwrt", enLSwrt, 0);
        checkOutput("rst_data", LSdata, 0);
        checkOutput("rst_misalign", misalignErr, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed: SW, LB/LBU, LW with wait states, LH wrap");
        applyStimulus(OP_SW, 32'h100, 32'h4, 32'hA1B2C3D4, 4'h5, 5'h07, 1);
        mem[32'h20] = 8'h80;
        applyStimulus(OP_LB, 32'h20, 32'h0, 32'h0, 4'h3, 5'h0A, 1);
        applyStimulus(OP_LBU, 32'h20, 32'h0, 32'h0, 4'h3, 5'h0B, 1);
        applyStimulus(OP_LW, 32'h100, 32'h4, 32'h0, 4'h9, 5'h11, 3);
        applyStimulus(OP_LH, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'h6, 5'h02, 1);

        $display("[TB] random operations");
        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                base = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
                off  = 32'($urandom_range(0, 7));
            end else begin
                base = 32'h1000 + 32'($urandom_range(0, 31));
                off  = 32'($urandom_range(0, 7));
            end
            applyStimulus(ops[$urandom_range(0, 7)], base, off, $urandom,
                          4'($urandom), 5'($urandom), $urandom_range(1, 3));
        end

        $display("[TB] reset during a store");
        @(negedge clk);
        ackLat = 3;
        wrQ.delete();
        rdQ.delete();
        opCode   = OP_SW;
        operandO = 32'h200;
        imm      = 32'h0;
        operandT = 32'h11223344;
        wrtTag   = 4'h1;
        wrtName  = 5'h01;
        LSworkEn = 1'b1;
        @(negedge clk);
        LSworkEn = 1'b0;
        j = 0;
        while (wrQ.size() < 2 && j < 100) begin
            @(negedge clk);
            j++;
        end
        checkOutput("rst_mid_reach", wrQ.size(), 2);
        @(negedge clk);
        checkOutput("rst_mid_req", memReq, 1);
        checkOutput("rst_mid_addr", memAddr, 32'h202);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_memreq", memReq, 0);
        checkOutput("rst_mid_memaddr", memAddr, 0);
        checkOutput("rst_mid_memwr", memWr, 0);
        checkOutput("rst_mid_wdata", memWdata, 0);
        checkOutput("rst_mid_done", LSdone, 0);
        checkOutput("rst_mid_enwrt", enLSwrt, 0);
        checkOutput("rst_mid_ready", LSreadEn, 1);
        repeat (2) @(negedge clk);
        checkOutput("rst_mid_no_more_wr", wrQ.size(), 2);
        rst = 1'b0;
        expErr = 1'b0;
        @(negedge clk);
        checkOutput("rst_rel_ready", LSreadEn, 1);
        applyStimulus(OP_LB, 32'h200, 32'h0, 32'h0, 4'hC, 5'h1C, 1);

        checkOutput("req_stable", stabErr, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ls_unit.md
# ls_unit

Load/store execution unit directly downstream of the load/store buffer. It accepts one issued memory operation at a time and computes the effective address. It runs the access byte-by-byte over the shared byte-wide memory-controller port. It then broadcasts load results on the LS common-data bus and pulses `LSdone` so the buffer can retire its head entry.

## Interface
Parameters:
- `DATA_W`, default 32: operand, address and result width.
- `TAG_W`, default 4: rename tag width, matching the tag bus.
- `NAME_W`, default 5: architectural register name width.
- `OP_W`, default 6: opcode width. Encodings are `LB`/`LH`/`LW`/`LBU`/`LHU`/`SB`/`SH`/`SW` from defines.v.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `LSworkEn` in 1: issued operation valid from the buffer.
- `operandO` in DATA_W: base register value.
- `operandT` in DATA_W: store data.
- `imm` in DATA_W: address offset.
- `wrtTag` in TAG_W: destination tag.
- `wrtName` in NAME_W: destination name.
- `opCode` in OP_W: operation.
- `LSreadEn` out 1: unit can accept an operation next cycle.
- `LSdone` out 1: one-cycle completion pulse, for loads and stores.
- `enLSwrt` out 1: load result valid.
- `LStag` out TAG_W: result tag.
- `LSname` out NAME_W: result name.
- `LSdata` out DATA_W: result data.
- `memReq` out 1: byte access request.
- `memWr` out 1: request is a write.
- `memAddr` out DATA_W: byte address.
- `memWdata` out 8: write byte.
- `memAck` in 1: controller completed the current byte.
- `memRdata` in 8: read byte, valid with `memAck`.
- `misalignErr` out 1: sticky error flag (see Configuration).

## Operation
- State machine states: IDLE, ACCESS, DONE.
- IDLE: on `LSworkEn`, latch the operation.
  - addr = operandO + imm, modulo 2^DATA_W.
  - Byte count n = 1 for B/BU, 2 for H/HU, 4 for W.
  - Clear byte counter k; go to ACCESS.
- ACCESS:
  - Drive memReq=1, memAddr=addr+k (wraps modulo 2^DATA_W), memWr for stores, memWdata=store byte k.
  - Byte k of a word is bits [8k+7:8k] (little-endian).
  - Request signals are held stable until `memAck`.
  - On each memAck: loads capture memRdata into byte k; k increments.
  - On the ack for byte n-1: go to DONE.
- DONE: one cycle.
  - LSdone=1; go to IDLE, or straight to ACCESS if `LSworkEn` is high.
  - Loads only: enLSwrt=1, LStag/LSname from the latched op, LSdata = assembled value.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores never assert enLSwrt.
- `LSreadEn` = (state==IDLE or DONE) and not LSworkEn.
  - The buffer issues with a registered output, so no second issue can land while busy.
- `LSworkEn` in ACCESS is a protocol violation: ignored, and flagged by assertion in simulation.
- memAck while memReq=0 is ignored.

## Timing
- Reset (asynchronous, any state including mid-access): state=IDLE, k=0, misalignErr=0.
  - All outputs 0, except LSreadEn=1 (combinational).
  - A partially performed store is not rolled back.
- Outputs other than LSreadEn are registered.
- LSworkEn sampled at edge e: memReq rises in the cycle after e.
- With memAck every cycle, the final ack is sampled at edge e+n, and LSdone/enLSwrt are high during cycle e+n+1.
  - LB: 2 cycles from LSworkEn to LSdone; LW: 5.
- Controller wait states add cycles one-for-one.
- Back-to-back operations: LSworkEn may arrive in the DONE cycle; the next memReq follows one cycle later.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - Halfword access with addr[0]=1, or word access with addr[1:0]≠0, skips ACCESS and goes IDLE→DONE.
  - No memReq is issued.
  - Loads broadcast LSdata=0 with their tag; LSdone pulses; misalignErr is set and held until reset.
- Macro undefined:
  - Misaligned accesses proceed byte-sequentially like any other access.
  - misalignErr is tied to 0.

## Test plan
- SW operandO=0x100, imm=4, operandT=0xA1B2C3D4, memAck every cycle.
  - Expect writes to 0x104..0x107 of D4, C3, B2, A1.
  - LSdone in cycle 5; enLSwrt stays 0.
- LB from 0x20 with memRdata=0x80, tag 3.
  - Expect enLSwrt=1, LStag=3, LSdata=0xFFFFFF80, 2 cycles after LSworkEn.
  - LBU of the same byte gives 0x00000080.
- LW with memAck delayed 3 cycles per byte.
  - memAddr held stable until each ack; LSdone 13 cycles after LSworkEn; no second issue accepted while busy.
- Address wrap: LH operandO=0xFFFFFFFF, imm=0.
  - Bytes accessed at 0xFFFFFFFF then 0x00000000 (macro undefined).
  - Macro defined: no memReq, LSdata=0, misalignErr=1.
- Assert rst during byte 2 of an SW.
  - memReq drops asynchronously and all outputs go to 0.
  - After release, LSreadEn=1 and a new LB completes normally.
